spi_dma_rw: RTL and testbench
=============================

Name: spi_dma_rw

Overview:
- Bidirectional multi-block DMA engine between the floppy-controller SPI byte port and the 6502-side memory bus.
- Successor of the read-only SD DMA: adds write direction (memory to SD), parametrised block size, address width and block count, start-token timeout, write-response check and error status.
- Sits between the workhorse CPU port decoder, the spi byte engine and the memory mux; stalls the CPU while busy.

Parameters:
- ADDR_W, 16, memory address width.
- BLK_BYTES, 512, bytes per block (power of two, 2..4096).
- NBLK_W, 4, width of the block-count input.
- TOKEN, 8'hFE, SD data start token.
- POLL_MAX, 255, maximum byte polls for the start token (read) or busy release (write) before error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; FSM and counters advance only when ce=1
- start  in  1  one-ce-cycle pulse; accepted only when busy=0
- dir  in  1  0=read SD to memory, 1=write memory to SD; sampled at start
- iaddr  in  ADDR_W  first memory address; sampled at start
- nblocks  in  NBLK_W  block count; sampled at start; 0 = no-op
- busy  out  1  high from the ce-cycle after an accepted start until DONE
- error  out  1  sticky; cleared by the next accepted start
- mem_addr  out  ADDR_W  memory address
- mem_odata  out  8  write data to memory
- mem_wr  out  1  memory write strobe, one ce-cycle
- mem_rd  out  1  memory read strobe; mem_idata is valid on the next ce-cycle
- mem_idata  in  8  memory read data
- spi_di  out  8  byte to transmit
- spi_wr  out  1  one ce-cycle transfer request
- spi_do  in  8  last received byte
- spi_dsr  in  1  1 = SPI idle and spi_do valid

Behaviour:
- Reset values: busy=0, error=0, all strobes=0, spi_di=8'hFF, mem_addr=0, mem_odata=0, state IDLE.
- Start handling: an accepted start latches dir, iaddr, nblocks and clears error. nblocks=0 goes straight to DONE.
- Byte transfer primitive XFER(b):
  - cycle 0: spi_di=b, spi_wr=1.
  - cycle 1: spi_dsr is ignored.
  - then wait until spi_dsr=1; spi_do is then the received byte.
- Read path: RD_TOKEN, RD_DATA, RD_CRC.
  - RD_TOKEN: XFER(FF) repeatedly. Received TOKEN goes to RD_DATA. Any other byte increments the poll counter; on the POLL_MAX-th failure, set error and go to DONE.
  - RD_DATA: for each byte, XFER(FF), then mem_odata=spi_do, mem_wr=1 one ce-cycle at mem_addr, then mem_addr+1. Exactly BLK_BYTES bytes.
  - RD_CRC: two XFER(FF), received bytes discarded.
- Write path: WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
  - WR_TOKEN: XFER(TOKEN).
  - WR_DATA: for each byte, mem_rd=1 for one ce-cycle, latch mem_idata on the next ce-cycle, XFER(latched), then mem_addr+1. BLK_BYTES bytes.
  - WR_CRC: XFER(FF) twice.
  - WR_RESP: XFER(FF). If (spi_do & 8'h1F)==8'h05, go to WR_BUSY; otherwise set error and go to DONE.
  - WR_BUSY: XFER(FF) until the received byte is nonzero; POLL_MAX polls, then error and DONE.
- Block loop: after a block, decrement the remaining count. Nonzero restarts at RD_TOKEN/WR_TOKEN with mem_addr continuing contiguously. Zero goes to DONE.
- DONE: busy=0 and return to IDLE in one ce-cycle.
- Address arithmetic: mem_addr wraps modulo 2^ADDR_W with no error. The byte counter is log2(BLK_BYTES) bits and the poll counter 8 bits, both reset per phase.
- start while busy: ignored, no effect on the latched parameters.
- Simultaneous start and ce=0: the start is not accepted.
- reset_n low mid-transfer: immediate return to reset values; the partial block is abandoned. The SPI engine finishes its own byte independently.
- ce low: all outputs hold; strobes are gated so they never last more than one ce-enabled cycle.
- mem_wr and mem_rd are never both high; spi_wr is never asserted while a previous XFER is waiting.

Test Plan:
- Read, 1 block, BLK_BYTES=512, iaddr=0x0800: SPI model returns FF,FF,FE, then bytes i&0xFF, then 2 CRC. Expect 512 mem_wr at 0x0800..0x09FF with data 00..FF repeating, 517 spi_wr total, error=0, busy low after DONE.
- Read, 3 blocks at iaddr=0xFF00 with ADDR_W=16: expect contiguous writes wrapping past 0xFFFF to 0x0000..0x04FF, and 3 token searches.
- Read timeout: model always returns FF. Expect exactly 255 polls in RD_TOKEN, then error=1, busy=0, no mem_wr.
- Write, 2 blocks from iaddr=0x0200: memory preloaded with pattern; model returns E5 as response then 00,00,FF. Expect a TOKEN byte per block, data bytes in spi_di order equal to memory, two FF CRC bytes, error=0.
- Write rejected: response byte 0x0B. Expect error=1 after the first block, no second token; a new start clears error.
- Reset mid-read after 100 bytes; start pulse while busy; ce held low for 5-cycle stretches. Expect all outputs at reset values after reset, the mid-busy start ignored, and strobe counts unchanged by ce stalls.

Source files
------------

// File: rtl/spi_dma_rw_if.sv
// Memory-side and SPI-byte-engine-side signals of the SPI block DMA engine.
// The DMA engine drives the master modport; memory mux and SPI engine sit on the slave side.
interface spi_dma_rw_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_odata;
    logic              mem_wr;
    logic              mem_rd;
    logic [7:0]        mem_idata;
    logic [7:0]        spi_di;
    logic              spi_wr;
    logic [7:0]        spi_do;
    logic              spi_dsr;

    modport master (
        output mem_addr, mem_odata, mem_wr, mem_rd, spi_di, spi_wr,
        input  mem_idata, spi_do, spi_dsr
    );

    modport slave (
        input  mem_addr, mem_odata, mem_wr, mem_rd, spi_di, spi_wr,
        output mem_idata, spi_do, spi_dsr
    );
endinterface

// File: rtl/spi_dma_rw.sv
// Bidirectional multi-block DMA between the SPI byte engine and the 6502 memory bus.
// Read: token search, data to memory, CRC skip. Write: token, memory to SD, CRC, response, busy wait.
module spi_dma_rw #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BLK_BYTES = 512,
    parameter int unsigned NBLK_W    = 4,
    parameter logic [7:0]  TOKEN     = 8'hFE,
    parameter int unsigned POLL_MAX  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [NBLK_W-1:0] nblocks,
    output logic              busy,
    output logic              error,
    spi_dma_rw_if.master      bus
);

    localparam int unsigned BW        = $clog2(BLK_BYTES);
    localparam logic [BW-1:0] LAST    = BW'(BLK_BYTES - 1);
    localparam logic [7:0] POLL_LAST  = 8'(POLL_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_TOKEN,
        S_RD_DATA,
        S_RD_STORE,
        S_RD_CRC,
        S_WR_TOKEN,
        S_WR_FETCH,
        S_WR_RDWAIT,
        S_WR_LATCH,
        S_WR_DATA,
        S_WR_CRC,
        S_WR_RESP,
        S_WR_BUSY,
        S_DONE
    } state_e;

    // Byte-transfer sub-phase: request, two cycles where spi_dsr is stale, then wait for idle.
    typedef enum logic [1:0] {
        XS_SEND,
        XS_ISSUED,
        XS_SKIP,
        XS_WAIT
    } xfer_e;

    state_e            state_q, state_d;
    xfer_e             xst_q, xst_d;
    logic              dir_q, dir_d;
    logic [NBLK_W-1:0] nblk_q, nblk_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [7:0]        poll_q, poll_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        odata_q, odata_d;
    logic [7:0]        spi_di_q, spi_di_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              spi_wr_q, spi_wr_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              is_xfer;
    logic              xfer_done;
    logic              blk_end;

    // State and output registers; everything holds while ce is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            xst_q    <= XS_SEND;
            dir_q    <= 1'b0;
            nblk_q   <= '0;
            byte_q   <= '0;
            poll_q   <= '0;
            addr_q   <= '0;
            odata_q  <= '0;
            spi_di_q <= 8'hFF;
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            spi_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            xst_q    <= xst_d;
            dir_q    <= dir_d;
            nblk_q   <= nblk_d;
            byte_q   <= byte_d;
            poll_q   <= poll_d;
            addr_q   <= addr_d;
            odata_q  <= odata_d;
            spi_di_q <= spi_di_d;
            mem_wr_q <= mem_wr_d;
            mem_rd_q <= mem_rd_d;
            spi_wr_q <= spi_wr_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        xst_d     = xst_q;
        dir_d     = dir_q;
        nblk_d    = nblk_q;
        byte_d    = byte_q;
        poll_d    = poll_q;
        addr_d    = addr_q;
        odata_d   = odata_q;
        spi_di_d  = spi_di_q;
        busy_d    = busy_q;
        error_d   = error_q;
        mem_wr_d  = 1'b0;
        mem_rd_d  = 1'b0;
        spi_wr_d  = 1'b0;
        blk_end   = 1'b0;
        is_xfer   = state_q inside {S_RD_TOKEN, S_RD_DATA, S_RD_CRC, S_WR_TOKEN,
                                    S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY};
        xfer_done = is_xfer && (xst_q == XS_WAIT) && bus.spi_dsr;

        // Shared byte-transfer sequencing for every state that moves a byte over SPI
        if (is_xfer) begin
            case (xst_q)
                XS_SEND: begin
                    spi_wr_d = 1'b1;
                    spi_di_d = (state_q == S_WR_TOKEN) ? TOKEN : 8'hFF;
                    xst_d    = XS_ISSUED;
                end
                XS_ISSUED: xst_d = XS_SKIP;
                XS_SKIP:   xst_d = XS_WAIT;
                default:   ;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    dir_d   = dir;
                    addr_d  = iaddr;
                    nblk_d  = nblocks;
                    error_d = 1'b0;
                    poll_d  = '0;
                    byte_d  = '0;
                    xst_d   = XS_SEND;
                    if (nblocks == '0) begin
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = dir ? S_WR_TOKEN : S_RD_TOKEN;
                    end
                end
            end
            S_RD_TOKEN: begin
                if (xfer_done) begin
                    xst_d = XS_SEND;
                    if (bus.spi_do == TOKEN) begin
                        byte_d  = '0;
                        state_d = S_RD_DATA;
                    end else if (poll_q == POLL_LAST) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        poll_d = poll_q + 8'd1;
                    end
                end
            end
            S_RD_DATA: begin
                if (xfer_done) begin
                    odata_d  = bus.spi_do;
                    mem_wr_d = 1'b1;
                    state_d  = S_RD_STORE;
                end
            end
            S_RD_STORE: begin
                addr_d = addr_q + ADDR_W'(1);
                xst_d  = XS_SEND;
                if (byte_q == LAST) begin
                    byte_d  = '0;
                    state_d = S_RD_CRC;
                end else begin
                    byte_d  = byte_q + BW'(1);
                    state_d = S_RD_DATA;
                end
            end
            S_RD_CRC: begin
                if (xfer_done) begin
                    xst_d = XS_SEND;
                    if (byte_q == BW'(1)) blk_end = 1'b1;
                    else                  byte_d  = BW'(1);
                end
            end
            S_WR_TOKEN: begin
                if (xfer_done) begin
                    xst_d   = XS_SEND;
                    byte_d  = '0;
                    state_d = S_WR_FETCH;
                end
            end
            S_WR_FETCH: begin
                mem_rd_d = 1'b1;
                state_d  = S_WR_RDWAIT;
            end
            S_WR_RDWAIT: state_d = S_WR_LATCH;
            // Read data is valid this cycle; the spi_di register doubles as the byte latch.
            S_WR_LATCH: begin
                spi_di_d = bus.mem_idata;
                spi_wr_d = 1'b1;
                xst_d    = XS_ISSUED;
                state_d  = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (xfer_done) begin
                    xst_d  = XS_SEND;
                    addr_d = addr_q + ADDR_W'(1);
                    if (byte_q == LAST) begin
                        byte_d  = '0;
                        state_d = S_WR_CRC;
                    end else begin
                        byte_d  = byte_q + BW'(1);
                        state_d = S_WR_FETCH;
                    end
                end
            end
            S_WR_CRC: begin
                if (xfer_done) begin
                    xst_d = XS_SEND;
                    if (byte_q == BW'(1)) begin
                        byte_d  = '0;
                        state_d = S_WR_RESP;
                    end else begin
                        byte_d = BW'(1);
                    end
                end
            end
            S_WR_RESP: begin
                if (xfer_done) begin
                    xst_d = XS_SEND;
                    if ((bus.spi_do & 8'h1F) == 8'h05) begin
                        poll_d  = '0;
                        state_d = S_WR_BUSY;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_WR_BUSY: begin
                if (xfer_done) begin
                    xst_d = XS_SEND;
                    if (bus.spi_do != 8'h00) begin
                        blk_end = 1'b1;
                    end else if (poll_q == POLL_LAST) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        poll_d = poll_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Block finished: next block continues at the current address, or finish
        if (blk_end) begin
            xst_d  = XS_SEND;
            poll_d = '0;
            byte_d = '0;
            nblk_d = nblk_q - NBLK_W'(1);
            if (nblk_q == NBLK_W'(1)) begin
                busy_d  = 1'b0;
                state_d = S_DONE;
            end else begin
                state_d = dir_q ? S_WR_TOKEN : S_RD_TOKEN;
            end
        end
    end

    assign busy          = busy_q;
    assign error         = error_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_odata = odata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.spi_di    = spi_di_q;
    assign bus.spi_wr    = spi_wr_q;

endmodule

// File: tb/tb_spi_dma_rw.sv
// Directed bench for spi_dma_rw: SPI byte-engine and memory models driven from one thread.
// Strobes are counted only on ce-enabled edges, which is where the consumers act on them.
module tb_spi_dma_rw;
    localparam int unsigned ADDR_W = 16;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        start;
    logic        dir;
    logic [15:0] iaddr;
    logic [3:0]  nblocks;
    logic        busy;
    logic        error;

    spi_dma_rw_if #(.ADDR_W(ADDR_W)) bus ();

    spi_dma_rw #(
        .ADDR_W(ADDR_W), .BLK_BYTES(512), .NBLK_W(4), .TOKEN(8'hFE), .POLL_MAX(255)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .start(start), .dir(dir),
        .iaddr(iaddr), .nblocks(nblocks), .busy(busy), .error(error), .bus(bus)
    );

    int n_checks, n_err;
    int n_spi_wr, n_mem_wr, n_mem_rd, wr_bad, both_hi, overlap, spi_cnt, cyc, tx_bad;
    logic stall;
    logic [7:0]  mem [0:65535];
    logic [7:0]  resp_q[$];
    logic [15:0] exp_a[$];
    logic [7:0]  exp_d[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_tx[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe what the coming edge consumes, then update the models after it.
    task automatic tick();
        logic        acc;
        logic        rdp;
        logic [15:0] ra;
        logic [15:0] ea;
        logic [7:0]  ed;
        acc = 1'b0;
        rdp = 1'b0;
        ra  = '0;
        @(negedge clk);
        if (ce) begin
            if (bus.mem_wr && bus.mem_rd) both_hi++;
            if (bus.mem_wr) begin
                n_mem_wr++;
                if (exp_a.size() == 0) wr_bad++;
                else begin
                    ea = exp_a.pop_front();
                    ed = exp_d.pop_front();
                    if (bus.mem_addr !== ea || bus.mem_odata !== ed) wr_bad++;
                end
            end
            if (bus.mem_rd) begin
                n_mem_rd++;
                rdp = 1'b1;
                ra  = bus.mem_addr;
            end
            if (bus.spi_wr) begin
                n_spi_wr++;
                if (spi_cnt != 0 || !bus.spi_dsr) overlap++;
                tx_q.push_back(bus.spi_di);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        // dsr stays high for one cycle after acceptance, then drops until the byte is back
        if (acc) spi_cnt = 3;
        else if (spi_cnt > 0) begin
            spi_cnt--;
            if (spi_cnt == 2) bus.spi_dsr = 1'b0;
            if (spi_cnt == 0) begin
                if (resp_q.size() > 0) bus.spi_do = resp_q.pop_front();
                else                   bus.spi_do = 8'hFF;
                bus.spi_dsr = 1'b1;
            end
        end
        if (rdp) bus.mem_idata = mem[ra];
        cyc++;
    endtask

    task automatic clr();
        n_spi_wr = 0; n_mem_wr = 0; n_mem_rd = 0; wr_bad = 0;
        resp_q.delete(); exp_a.delete(); exp_d.delete(); tx_q.delete(); exp_tx.delete();
    endtask

    task automatic do_start(input logic d, input logic [15:0] a, input logic [3:0] n);
        dir = d; iaddr = a; nblocks = n; start = 1'b1; ce = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            ce = !(stall && (cyc % 18) >= 13);
            tick();
            k++;
        end
        ce = 1'b1;
        tick();
        chk({tag, "_timeout"}, 32'(k >= budget), 32'd0);
    endtask

    task automatic count_tx_bad(output int bad);
        bad = 0;
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
            if (tx_q[i] !== exp_tx[i]) bad++;
    endtask

    initial begin
        int k;
        n_checks = 0; n_err = 0; both_hi = 0; overlap = 0; spi_cnt = 0; cyc = 0; stall = 1'b0;
        reset_n = 1'b0; ce = 1'b1; start = 1'b0; dir = 1'b0; iaddr = '0; nblocks = '0;
        bus.spi_dsr = 1'b1; bus.spi_do = 8'hFF; bus.mem_idata = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 5 + 3);
        clr();

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_strobes", {29'd0, bus.mem_wr, bus.mem_rd, bus.spi_wr}, 32'd0);
        chk("rst_spi_di", 32'(bus.spi_di), 32'hFF);
        chk("rst_addr_odata", {bus.mem_addr, 8'd0, bus.mem_odata}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Read one block at 0x0800
        clr();
        resp_q.push_back(8'hFF); resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
            resp_q.push_back(8'(i));
            exp_a.push_back(16'(32'h0800 + i));
            exp_d.push_back(8'(i));
        end
        resp_q.push_back(8'hAA); resp_q.push_back(8'h55);
        do_start(1'b0, 16'h0800, 4'd1);
        wait_idle("rd1", 20000);
        chk("rd1_wr_cnt", 32'(n_mem_wr), 32'd512);
        chk("rd1_wr_bad", 32'(wr_bad), 32'd0);
        chk("rd1_spi_cnt", 32'(n_spi_wr), 32'd517);
        chk("rd1_error", 32'(error), 32'd0);
        chk("rd1_busy", 32'(busy), 32'd0);
        chk("rd1_end_addr", 32'(bus.mem_addr), 32'h0A00);
        k = 0;
        for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== 8'hFF) k++;
        chk("rd1_tx_not_ff", 32'(k), 32'd0);

        // Read three blocks wrapping past 0xFFFF
        clr();
        for (int b = 0; b < 3; b++) begin
            resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
            for (int i = 0; i < 512; i++) begin
                resp_q.push_back(8'(b * 3 + i));
                exp_a.push_back(16'(32'hFF00 + b * 512 + i));
                exp_d.push_back(8'(b * 3 + i));
            end
            resp_q.push_back(8'h12); resp_q.push_back(8'h34);
        end
        do_start(1'b0, 16'hFF00, 4'd3);
        wait_idle("rd3", 40000);
        chk("rd3_wr_cnt", 32'(n_mem_wr), 32'd1536);
        chk("rd3_wr_bad", 32'(wr_bad), 32'd0);
        chk("rd3_spi_cnt", 32'(n_spi_wr), 32'd1548);
        chk("rd3_error", 32'(error), 32'd0);
        chk("rd3_end_addr", 32'(bus.mem_addr), 32'h0500);

        // Token never arrives
        clr();
        do_start(1'b0, 16'h3000, 4'd1);
        wait_idle("rdto", 20000);
        chk("rdto_polls", 32'(n_spi_wr), 32'd255);
        chk("rdto_error", 32'(error), 32'd1);
        chk("rdto_busy", 32'(busy), 32'd0);
        chk("rdto_wr_cnt", 32'(n_mem_wr), 32'd0);

        // Write two blocks from 0x0200, response E5, busy for two polls
        clr();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 515; i++) resp_q.push_back(8'hFF);
            resp_q.push_back(8'hE5); resp_q.push_back(8'h00);
            resp_q.push_back(8'h00); resp_q.push_back(8'hFF);
            exp_tx.push_back(8'hFE);
            for (int i = 0; i < 512; i++) exp_tx.push_back(mem[16'(32'h0200 + b * 512 + i)]);
            for (int i = 0; i < 6; i++) exp_tx.push_back(8'hFF);
        end
        do_start(1'b1, 16'h0200, 4'd2);
        wait_idle("wr2", 40000);
        count_tx_bad(tx_bad);
        chk("wr2_tx_cnt", 32'(tx_q.size()), 32'd1038);
        chk("wr2_tx_bad", 32'(tx_bad), 32'd0);
        chk("wr2_rd_cnt", 32'(n_mem_rd), 32'd1024);
        chk("wr2_wr_cnt", 32'(n_mem_wr), 32'd0);
        chk("wr2_error", 32'(error), 32'd0);
        chk("wr2_end_addr", 32'(bus.mem_addr), 32'h0600);

        // Write rejected after the first block
        clr();
        for (int i = 0; i < 515; i++) resp_q.push_back(8'hFF);
        resp_q.push_back(8'h0B);
        exp_tx.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_tx.push_back(mem[16'(32'h0300 + i)]);
        for (int i = 0; i < 3; i++) exp_tx.push_back(8'hFF);
        do_start(1'b1, 16'h0300, 4'd2);
        wait_idle("wrrej", 20000);
        count_tx_bad(tx_bad);
        chk("wrrej_tx_cnt", 32'(tx_q.size()), 32'd516);
        chk("wrrej_tx_bad", 32'(tx_bad), 32'd0);
        chk("wrrej_error", 32'(error), 32'd1);
        clr();
        do_start(1'b0, 16'h0000, 4'd0);
        tick();
        chk("zero_blk_error_clr", 32'(error), 32'd0);
        chk("zero_blk_busy", 32'(busy), 32'd0);
        chk("zero_blk_spi", 32'(n_spi_wr), 32'd0);

        // Start together with ce=0 is not accepted
        clr();
        dir = 1'b0; iaddr = 16'h4000; nblocks = 4'd1; ce = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; ce = 1'b1;
        repeat (3) tick();
        chk("ce0_start_busy", 32'(busy), 32'd0);
        chk("ce0_start_spi", 32'(n_spi_wr), 32'd0);

        // Reset after 100 data bytes of a read
        clr();
        resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
            resp_q.push_back(8'(i ^ 7));
            exp_a.push_back(16'(32'h1000 + i));
            exp_d.push_back(8'(i ^ 7));
        end
        do_start(1'b0, 16'h1000, 4'd1);
        k = 0;
        while (n_mem_wr < 100 && k < 5000) begin
            tick();
            k++;
        end
        chk("rstmid_wait_timeout", 32'(k >= 5000), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_strobes", {29'd0, bus.mem_wr, bus.mem_rd, bus.spi_wr}, 32'd0);
        chk("rstmid_spi_di", 32'(bus.spi_di), 32'hFF);
        chk("rstmid_addr_odata", {bus.mem_addr, 8'd0, bus.mem_odata}, 32'd0);
        chk("rstmid_wr_bad", 32'(wr_bad), 32'd0);
        resp_q.delete(); exp_a.delete(); exp_d.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();

        // Read with an ignored start while busy and ce stall stretches
        clr();
        resp_q.push_back(8'hFF); resp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
            resp_q.push_back(8'(i * 7));
            exp_a.push_back(16'(32'h2000 + i));
            exp_d.push_back(8'(i * 7));
        end
        resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        do_start(1'b0, 16'h2000, 4'd1);
        repeat (20) tick();
        dir = 1'b1; iaddr = 16'h7777; nblocks = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b1;
        wait_idle("stall", 40000);
        stall = 1'b0;
        chk("stall_wr_cnt", 32'(n_mem_wr), 32'd512);
        chk("stall_wr_bad", 32'(wr_bad), 32'd0);
        chk("stall_spi_cnt", 32'(n_spi_wr), 32'd516);
        chk("stall_rd_cnt", 32'(n_mem_rd), 32'd0);
        chk("stall_error", 32'(error), 32'd0);
        chk("stall_end_addr", 32'(bus.mem_addr), 32'h2200);
        chk("stall_busy", 32'(busy), 32'd0);

        chk("mem_wr_rd_overlap", 32'(both_hi), 32'd0);
        chk("spi_wr_while_busy", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
